// File: rtl/crossbar_scheduler.sv
// Per-byte scheduler for the 3x3 switch fabric: pops ingress FIFOs, decodes the
// destination in bits [7:6], arbitrates each output round-robin and drives registered mux selects.
module crossbar_scheduler #(
    parameter int DROP_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              empty1,
    input  logic              empty2,
    input  logic              empty3,
    input  logic [7:0]        data1,
    input  logic [7:0]        data2,
    input  logic [7:0]        data3,
    input  logic              out_ready1,
    input  logic              out_ready2,
    input  logic              out_ready3,
    output logic              rdreq1,
    output logic              rdreq2,
    output logic              rdreq3,
    output logic [1:0]        sel1,
    output logic [1:0]        sel2,
    output logic [1:0]        sel3,
    output logic [DROP_W-1:0] drop_count
);

    typedef enum logic [1:0] {IDLE, HOLD, XFER} state_t;

    state_t            state_q [3];
    state_t            state_d [3];
    logic [1:0]        dest    [3];
    logic [2:0]        empty_v;
    logic [2:0]        ready_v;
    logic [2:0]        req     [3];
    logic [1:0]        win     [3];
    logic [1:0]        sel_q   [3];
    logic [1:0]        ptr_q   [3];
    logic [2:0]        grant;
    logic [2:0]        rdreq_c;
    logic [2:0]        drop;
    logic [1:0]        n_drop;
    logic [DROP_W-1:0] drop_q;

    // The payload bits only pass through the external mux.
    logic payload_unused;
    assign payload_unused = ^{data1[5:0], data2[5:0], data3[5:0]};

    assign dest[0] = data1[7:6];
    assign dest[1] = data2[7:6];
    assign dest[2] = data3[7:6];
    assign empty_v = {empty3, empty2, empty1};
    assign ready_v = {out_ready3, out_ready2, out_ready1};

    // Search ptr+1, ptr+2, ptr (values 1..3); returns 0 when nobody requests.
    function automatic logic [1:0] rr_pick(input logic [1:0] ptr, input logic [2:0] rq);
        logic [1:0] c;
        rr_pick = 2'd0;
        c = ptr;
        for (int n = 0; n < 3; n++) begin
            c = (c == 2'd3) ? 2'd1 : c + 2'd1;
            if (rr_pick == 2'd0 && rq[c - 2'd1])
                rr_pick = c;
        end
    endfunction

    function automatic logic [DROP_W-1:0] sat_add(input logic [DROP_W-1:0] cnt,
                                                  input logic [1:0] inc);
        logic [DROP_W:0] s;
        s = {1'b0, cnt} + {{(DROP_W-1){1'b0}}, inc};
        sat_add = s[DROP_W] ? {DROP_W{1'b1}} : s[DROP_W-1:0];
    endfunction

    always_comb begin
        for (int k = 0; k < 3; k++) begin
            req[k] = 3'b000;
            for (int i = 0; i < 3; i++)
                req[k][i] = (state_q[i] == HOLD) && (dest[i] == 2'(k + 1));
            win[k] = ready_v[k] ? rr_pick(ptr_q[k], req[k]) : 2'd0;
        end
        for (int i = 0; i < 3; i++) begin
            grant[i] = 1'b0;
            for (int k = 0; k < 3; k++)
                if (win[k] == 2'(i + 1))
                    grant[i] = 1'b1;
        end
    end

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            state_d[i] = state_q[i];
            rdreq_c[i] = 1'b0;
            drop[i]    = 1'b0;
            case (state_q[i])
                IDLE: begin
                    rdreq_c[i] = !empty_v[i];
                    if (rdreq_c[i])
                        state_d[i] = HOLD;
                end
                HOLD: begin
                    if (dest[i] == 2'b00) begin
                        drop[i]    = 1'b1;
                        rdreq_c[i] = !empty_v[i];
                        state_d[i] = rdreq_c[i] ? HOLD : IDLE;
                    end else if (grant[i]) begin
                        state_d[i] = XFER;
                    end
                end
                XFER: begin
                    // The pop lands on the closing edge, so the forwarded byte stays on the mux.
                    rdreq_c[i] = !empty_v[i];
                    state_d[i] = rdreq_c[i] ? HOLD : IDLE;
                end
                default: state_d[i] = IDLE;
            endcase
        end
        n_drop = 2'(drop[0]) + 2'(drop[1]) + 2'(drop[2]);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 3; i++) begin
                state_q[i] <= IDLE;
                sel_q[i]   <= 2'd0;
                ptr_q[i]   <= 2'd3;
            end
            drop_q <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                state_q[i] <= state_d[i];
                sel_q[i]   <= win[i];
                if (win[i] != 2'd0)
                    ptr_q[i] <= win[i];
            end
            drop_q <= sat_add(drop_q, n_drop);
        end
    end

    assign rdreq1     = reset_n & rdreq_c[0];
    assign rdreq2     = reset_n & rdreq_c[1];
    assign rdreq3     = reset_n & rdreq_c[2];
    assign sel1       = sel_q[0];
    assign sel2       = sel_q[1];
    assign sel3       = sel_q[2];
    assign drop_count = drop_q;

endmodule

// File: tb/tb_crossbar_scheduler.sv
// Directed bench for crossbar_scheduler: three normal-mode FIFO models feed the
// scheduler, and the output mux is rebuilt from sel to check forwarded bytes.
module tb_crossbar_scheduler;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       empty1, empty2, empty3;
    logic [7:0] data1 = 8'h00, data2 = 8'h00, data3 = 8'h00;
    logic       out_ready1, out_ready2, out_ready3;
    logic       rdreq1, rdreq2, rdreq3;
    logic [1:0] sel1, sel2, sel3;
    logic [7:0] drop_count;

    logic [7:0] mem1 [0:511];
    logic [7:0] mem2 [0:511];
    logic [7:0] mem3 [0:511];
    int wr1 = 0, wr2 = 0, wr3 = 0;
    int rd1 = 0, rd2 = 0, rd3 = 0;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    crossbar_scheduler #(.DROP_W(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .empty1(empty1), .empty2(empty2), .empty3(empty3),
        .data1(data1), .data2(data2), .data3(data3),
        .out_ready1(out_ready1), .out_ready2(out_ready2), .out_ready3(out_ready3),
        .rdreq1(rdreq1), .rdreq2(rdreq2), .rdreq3(rdreq3),
        .sel1(sel1), .sel2(sel2), .sel3(sel3),
        .drop_count(drop_count)
    );

    assign empty1 = (rd1 == wr1);
    assign empty2 = (rd2 == wr2);
    assign empty3 = (rd3 == wr3);

    // Normal-mode FIFO: q shows the popped word after the edge where rdreq is high.
    always @(posedge clk) begin
        if (rdreq1) begin data1 <= mem1[rd1]; rd1 <= rd1 + 1; end
        if (rdreq2) begin data2 <= mem2[rd2]; rd2 <= rd2 + 1; end
        if (rdreq3) begin data3 <= mem3[rd3]; rd3 <= rd3 + 1; end
    end

    task automatic push(input int i, input logic [7:0] b);
        case (i)
            1: begin mem1[wr1] = b; wr1 = wr1 + 1; end
            2: begin mem2[wr2] = b; wr2 = wr2 + 1; end
            default: begin mem3[wr3] = b; wr3 = wr3 + 1; end
        endcase
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [7:0] mux(input logic [1:0] s);
        case (s)
            2'd1: mux = data1;
            2'd2: mux = data2;
            2'd3: mux = data3;
            default: mux = 8'h00;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [7:0] t2_b [3][3];
        logic [1:0] got_in [16];
        logic [7:0] got_b  [16];
        int n, other, nz;

        t2_b = '{'{8'h81, 8'h82, 8'h83}, '{8'h91, 8'h92, 8'h93}, '{8'hA1, 8'hA2, 8'hA3}};
        for (int j = 0; j < 16; j++) begin got_in[j] = 2'd0; got_b[j] = 8'h00; end

        reset_n = 1'b0;
        out_ready1 = 1'b1; out_ready2 = 1'b1; out_ready3 = 1'b1;
        #2;
        chk("rst_sel1", 32'(sel1), 0);
        chk("rst_sel2", 32'(sel2), 0);
        chk("rst_sel3", 32'(sel3), 0);
        chk("rst_drop", 32'(drop_count), 0);
        chk("rst_rdreq1", 32'(rdreq1), 0);
        cyc(2);
        reset_n = 1'b1;

        // single byte, uncontended latency
        cyc(1);
        push(1, 8'h45);
        #1 chk("t1_rdreq1_c0", 32'(rdreq1), 1);
        cyc(1); chk("t1_sel1_c1", 32'(sel1), 0);
        cyc(1); chk("t1_sel1_c2", 32'(sel1), 1);
        chk("t1_result1", 32'(mux(sel1)), 32'h45);
        cyc(1); chk("t1_sel1_c3", 32'(sel1), 0);
        chk("t1_rdreq1_c3", 32'(rdreq1), 0);

        // three inputs contending for out2
        cyc(1);
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                push(i + 1, t2_b[i][j]);
        n = 0; other = 0;
        for (int c = 0; c < 24; c++) begin
            cyc(1);
            if (sel2 != 2'd0 && n < 16) begin
                got_in[n] = sel2; got_b[n] = mux(sel2); n++;
            end
            if (sel1 != 2'd0 || sel3 != 2'd0) other++;
        end
        chk("t2_count", 32'(n), 9);
        chk("t2_other_sel", 32'(other), 0);
        for (int k = 0; k < 9; k++) begin
            chk($sformatf("t2_sel_%0d", k), 32'(got_in[k]), 32'(k % 3 + 1));
            chk($sformatf("t2_byte_%0d", k), 32'(got_b[k]), 32'(t2_b[k % 3][k / 3]));
        end

        // invalid destination drops and saturation
        for (int j = 0; j < 4; j++) push(2, 8'h05);
        nz = 0;
        for (int c = 0; c < 8; c++) begin
            cyc(1);
            if (sel1 != 2'd0 || sel2 != 2'd0 || sel3 != 2'd0) nz++;
        end
        chk("t3_sel_quiet", 32'(nz), 0);
        chk("t3_drop4", 32'(drop_count), 4);
        for (int j = 0; j < 249; j++) push(2, 8'h05);
        cyc(260);
        chk("t3_drop253", 32'(drop_count), 253);
        push(1, 8'h00); push(2, 8'h00); push(3, 8'h00);
        cyc(4);
        chk("t3_drop_sat3", 32'(drop_count), 255);
        push(2, 8'h3F);
        cyc(4);
        chk("t3_drop_hold", 32'(drop_count), 255);

        // back-pressure on out3
        out_ready3 = 1'b0;
        push(1, 8'hC7); push(1, 8'hC8);
        #1 chk("t4_rdreq1_c0", 32'(rdreq1), 1);
        for (int c = 0; c < 10; c++) begin
            cyc(1);
            chk($sformatf("t4_rdreq1_wait%0d", c), 32'(rdreq1), 0);
            chk($sformatf("t4_sel3_wait%0d", c), 32'(sel3), 0);
        end
        out_ready3 = 1'b1;
        cyc(1); chk("t4_sel3_go", 32'(sel3), 1);
        chk("t4_result_c7", 32'(mux(sel3)), 32'hC7);
        cyc(1); chk("t4_sel3_gap", 32'(sel3), 0);
        cyc(1); chk("t4_sel3_next", 32'(sel3), 1);
        chk("t4_result_c8", 32'(mux(sel3)), 32'hC8);

        // parallel non-conflicting transfers
        cyc(2);
        push(1, 8'h4A); push(2, 8'h8B); push(3, 8'hCC);
        cyc(2);
        chk("t5_sel1", 32'(sel1), 1);
        chk("t5_sel2", 32'(sel2), 2);
        chk("t5_sel3", 32'(sel3), 3);
        chk("t5_result1", 32'(mux(sel1)), 32'h4A);
        chk("t5_result2", 32'(mux(sel2)), 32'h8B);
        chk("t5_result3", 32'(mux(sel3)), 32'hCC);

        // reset during XFER, then pointer and FSM state after release
        cyc(2);
        push(2, 8'h95); push(2, 8'h96);
        cyc(2);
        chk("t6_sel2_xfer", 32'(sel2), 2);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_sel2_rst", 32'(sel2), 0);
        chk("t6_rdreq2_rst", 32'(rdreq2), 0);
        chk("t6_drop_rst", 32'(drop_count), 0);
        cyc(2);
        reset_n = 1'b1;
        push(1, 8'h81); push(3, 8'hA1);
        #1;
        chk("t6_rdreq1_rel", 32'(rdreq1), 1);
        chk("t6_rdreq2_rel", 32'(rdreq2), 1);
        cyc(2); chk("t6_sel2_a", 32'(sel2), 1);
        chk("t6_result_a", 32'(mux(sel2)), 32'h81);
        cyc(1); chk("t6_sel2_b", 32'(sel2), 2);
        chk("t6_result_b", 32'(mux(sel2)), 32'h96);
        cyc(1); chk("t6_sel2_c", 32'(sel2), 3);
        chk("t6_result_c", 32'(mux(sel2)), 32'hA1);

        cyc(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
